display_scanner_n: RTL
======================

DISPLAY_SCANNER_N -- requirements
Module: display_scanner_n

Interface
REQ-001 Parameter N_DIGITS, default 4, is the number of multiplexed 7-segment digits; the legal range is 1..8.
REQ-002 Parameter DIV, default 50000, is the number of clk cycles per digit slot; the minimum is 2.
REQ-003 Parameter BLINK_FRAMES, default 64, is the number of complete scan frames per blink half-period; the minimum is 1.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port load, input, 1 bit: a one-cycle request to capture codes and dp.
REQ-007 Port codes, input, 4*N_DIGITS bits: the digit codes, with digit 0 (rightmost) in bits [3:0].
REQ-008 Port dp, input, N_DIGITS bits: the decimal-point enable per digit, captured with codes.
REQ-009 Port blink_mask, input, N_DIGITS bits: the live per-digit blink enable, not latched.
REQ-010 Port lzb, input, 1 bit: the live leading-zero-blanking enable.
REQ-011 Port pend, output, 1 bit: high while captured data is waiting for the frame boundary.
REQ-012 Port segmentos, output, 8 bits: active-low segments in the order {dp,g,f,e,d,c,b,a}.
REQ-013 Port digit_n, output, N_DIGITS bits: active-low digit selects; at most one bit is low at any time.

Function
REQ-014 The prescaler shall count 0..DIV-1 and wrap; tick is asserted for the single cycle in which count equals DIV-1.
REQ-015 Digit index idx shall advance on tick and wrap from N_DIGITS-1 to 0; the cycle in which idx wraps is frame_end.
REQ-016 A load pulse shall copy codes and dp into a shadow register and set pend on the next edge.
- A second load while pend is high overwrites the shadow; the last load wins.
REQ-017 On frame_end with pend high, the shadow shall be copied to the active register and pend cleared.
- The active register changes only at frame boundaries, so no frame ever mixes old and new data.
REQ-018 If load and frame_end coincide, the active register shall take the previous shadow contents.
- The new data goes to the shadow, and pend remains high.
REQ-019 The code decode table shall be:
- 0x0-0x9: decimal digits
- 0xA: E
- 0xB: P
- 0xC: n
- 0xD: '-'
- 0xE: o
- 0xF: blank (all segments off)
REQ-020 Leading-zero blanking: when lzb=1, code 0x0 shall be forced to blank for every digit above the highest-index nonzero code.
- Digit 0 is never lzb-blanked.
- dp is also suppressed on lzb-blanked digits.
REQ-021 The blink phase bit shall toggle after every BLINK_FRAMES frame_end events.
- While the phase is 1, each digit with blink_mask=1 shall display blank with dp off.
REQ-022 segmentos and digit_n shall be registered, and shall reflect idx and the active data with one clk cycle of latency.
REQ-023 The segment mask shall be 1 for every segment that is off, with dp segment low only when the active dp bit is 1 and the digit is not blanked.
REQ-024 digit_n shall drive low only the bit at position idx; a blanked digit still has its select driven.

Reset
REQ-025 While rst_n=0, the block shall set:
- prescaler, idx and blink phase to 0
- pend to 0
- shadow and active codes to 0xF, and dp to 0
- segmentos to 8'hFF and digit_n to all ones
REQ-026 After rst_n deasserts, the first selected digit shall appear on the cycle after the first rising edge, showing digit 0 as blank.
REQ-027 An assertion of rst_n mid-frame shall discard any pending shadow data, with no partial update of the active register.

Verification
All scenarios use N_DIGITS=4, DIV=4, BLINK_FRAMES=2.
REQ-028 Reset: hold rst_n=0 -> segmentos=8'hFF and digit_n=4'b1111. Release rst_n -> next cycle digit_n=4'b1110 and segmentos=8'hFF.
REQ-029 Scan order: load codes=16'h1234, then wait for the frame boundary:
- digit_n cycles 1110, 1101, 1011, 0111, with each value lasting 4 cycles
- digit 0 shows 4 as 8'b10011001
- digit 3 shows 1 as 8'b11111001
REQ-030 Tear-free update: pulse load mid-frame -> pend=1 until frame_end, and the old codes stay visible for the remaining digits. The next frame is all new data, and pend=0.
REQ-031 Coincidence: load A, then load B exactly on the frame_end cycle -> the next frame shows A, pend stays 1, and the following frame shows B.
REQ-032 LZB: codes=16'h0070 with lzb=1 -> digits 3 and 2 are blank, digit 1 shows 7, and digit 0 shows 0. With lzb=0, digits 3 and 2 show 0.
REQ-033 Blink: blink_mask=4'b0001 -> digit 0 is blank for 2 frames, visible for 2 frames, and alternates thereafter; digits 1-3 are never blanked by blink.

Source files
------------

// File: rtl/display_scanner_n_if.sv
// Bus bundle for the multiplexed 7-segment scanner: capture request, digit data,
// live display controls and the registered drive outputs.
interface display_scanner_n_if #(
   parameter int N_DIGITS = 4
);
   logic                    load;
   logic [4*N_DIGITS-1:0]   codes;
   logic [N_DIGITS-1:0]     dp;
   logic [N_DIGITS-1:0]     blink_mask;
   logic                    lzb;
   logic                    pend;
   logic [7:0]              segmentos;
   logic [N_DIGITS-1:0]     digit_n;

   modport master (
      output load, codes, dp, blink_mask, lzb,
      input  pend, segmentos, digit_n
   );

   modport slave (
      input  load, codes, dp, blink_mask, lzb,
      output pend, segmentos, digit_n
   );
endinterface

// File: rtl/display_scanner_n.sv
// Time-multiplexed 7-segment scanner with frame-synchronous double buffering,
// leading-zero blanking and per-digit blink. Outputs are active-low.
module display_scanner_n #(
   parameter int N_DIGITS     = 4,
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input logic                clk,
   input logic                rst_n,
   display_scanner_n_if.slave bus
);
   localparam int PW = $clog2(DIV);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int CW = 4 * N_DIGITS;

   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_idx;
   logic [BW-1:0]       r_bcnt;
   logic                r_phase;
   logic                r_pend;
   logic [CW-1:0]       r_sh_codes;
   logic [N_DIGITS-1:0] r_sh_dp;
   logic [CW-1:0]       r_act_codes;
   logic [N_DIGITS-1:0] r_act_dp;
   logic [7:0]          r_seg;
   logic [N_DIGITS-1:0] r_dig;

   logic                w_tick;
   logic                w_frame_end;
   logic [3:0]          w_code;
   logic                w_dp_sel;
   logic                w_bm_sel;
   logic                w_lz_sel;
   logic                w_above_zero;
   logic [N_DIGITS-1:0] w_lz;
   logic [N_DIGITS-1:0] w_sel_n;
   logic                w_blank;

   // Active-high {g,f,e,d,c,b,a}; inverted when driven onto the pins.
   function automatic logic [6:0] f_decode(input logic [3:0] code);
      case (code)
         4'h0:    f_decode = 7'h3F;
         4'h1:    f_decode = 7'h06;
         4'h2:    f_decode = 7'h5B;
         4'h3:    f_decode = 7'h4F;
         4'h4:    f_decode = 7'h66;
         4'h5:    f_decode = 7'h6D;
         4'h6:    f_decode = 7'h7D;
         4'h7:    f_decode = 7'h07;
         4'h8:    f_decode = 7'h7F;
         4'h9:    f_decode = 7'h6F;
         4'hA:    f_decode = 7'h79;
         4'hB:    f_decode = 7'h73;
         4'hC:    f_decode = 7'h54;
         4'hD:    f_decode = 7'h40;
         4'hE:    f_decode = 7'h5C;
         default: f_decode = 7'h00;
      endcase
   endfunction

   assign w_tick      = (r_presc == PW'(DIV - 1));
   assign w_frame_end = w_tick && (r_idx == IW'(N_DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
      end
   end

   // Shadow takes every load; active only moves at a frame boundary, and a load
   // landing on that same edge stays pending for the next boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend      <= 1'b0;
         r_sh_codes  <= '1;
         r_sh_dp     <= '0;
         r_act_codes <= '1;
         r_act_dp    <= '0;
      end else begin
         if (bus.load) begin
            r_sh_codes <= bus.codes;
            r_sh_dp    <= bus.dp;
         end
         if (w_frame_end && r_pend) begin
            r_act_codes <= r_sh_codes;
            r_act_dp    <= r_sh_dp;
         end
         if (bus.load)         r_pend <= 1'b1;
         else if (w_frame_end) r_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt  <= '0;
         r_phase <= 1'b0;
      end else if (w_frame_end) begin
         if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_bcnt <= r_bcnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_code       = 4'hF;
      w_dp_sel     = 1'b0;
      w_bm_sel     = 1'b0;
      w_lz_sel     = 1'b0;
      w_sel_n      = '1;
      w_lz         = '0;
      w_above_zero = 1'b1;
      // A digit is a leading zero when it and every digit above it are zero.
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         w_lz[i]      = w_above_zero && (r_act_codes[4*i +: 4] == 4'h0);
         w_above_zero = w_lz[i];
      end
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_code     = r_act_codes[4*i +: 4];
            w_dp_sel   = r_act_dp[i];
            w_bm_sel   = bus.blink_mask[i];
            w_lz_sel   = w_lz[i];
            w_sel_n[i] = 1'b0;
         end
      end
      w_blank = (bus.lzb && w_lz_sel) || (r_phase && w_bm_sel);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= 8'hFF;
         r_dig <= '1;
      end else begin
         r_seg <= {~(w_dp_sel && !w_blank), ~(w_blank ? 7'h00 : f_decode(w_code))};
         r_dig <= w_sel_n;
      end
   end

   assign bus.pend      = r_pend;
   assign bus.segmentos = r_seg;
   assign bus.digit_n   = r_dig;
endmodule
